// File: rtl/loader_pkg.sv
// Shared definitions for the boot-image loader: FSM encoding, default memory
// geometry and header/word framing constants.
package loader_pkg;

  localparam int DEPTH_DEF  = 1024;
  localparam int ADDR_W_DEF = 10;
  localparam int HDR_BYTES  = 2;
  localparam int CNT_W      = 8 * HDR_BYTES;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    DONE,
    ERR
  } state_t;

  typedef struct packed {
    logic rx_ready;
    logic done;
    logic error;
    logic core_reset;
  } ctrl_t;

  // Status outputs are a pure function of the state being entered.
  function automatic ctrl_t ctrl_for(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      HDR_LO, HDR_HI, DATA: c.rx_ready = 1'b1;
      DONE: begin
        c.done       = 1'b1;
        c.core_reset = 1'b1;
      end
      ERR:     c.error = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/loader_word_pack.sv
// Packs accepted bytes little-endian into 32-bit words; flags the byte that
// completes a word so the caller can register the write in the same edge.
module loader_word_pack
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_ready,
  output logic [31:0] o_word
);

  localparam int SHIFT_W = 8 * (WORD_BYTES - 1);

  logic [SHIFT_W-1:0] r_shift;
  logic [1:0]         r_byte_cnt;

  // The final byte of a word is never stored; it is merged on the fly.
  assign o_word_ready = i_byte_valid && (r_byte_cnt == 2'(WORD_BYTES - 1));
  assign o_word       = {i_byte, r_shift};

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else if (i_clear) begin
      r_byte_cnt <= '0;
    end else if (i_byte_valid) begin
      r_shift    <= {i_byte, r_shift[SHIFT_W-1:8]};
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Boot loader: receives a length-prefixed image from a byte stream, writes it
// into instruction memory and holds the core in reset until the image is in.
module mem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             r_state;
  state_t             w_next;
  ctrl_t              r_ctrl;
  logic [CNT_W-1:0]   r_count;
  logic [ADDR_W-1:0]  r_word_idx;
  logic [IDLE_W-1:0]  r_idle;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_wdata;

  logic               w_accept;
  logic               w_clear;
  logic               w_timeout;
  logic               w_last_word;
  logic [CNT_W-1:0]   w_hdr_count;
  logic               w_word_ready;
  logic [31:0]        w_word;

  assign w_accept    = rx_valid && r_ctrl.rx_ready;
  assign w_clear     = load_req && (r_state inside {DONE, ERR});
  assign w_timeout   = (r_idle == IDLE_W'(TIMEOUT - 1));
  assign w_hdr_count = {rx_data, r_count[7:0]};
  assign w_last_word = (CNT_W'(r_word_idx) == r_count - CNT_W'(1));

  loader_word_pack u_pack (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_clear),
    .i_byte_valid (w_accept && (r_state == DATA)),
    .i_byte       (rx_data),
    .o_word_ready (w_word_ready),
    .o_word       (w_word)
  );

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      HDR_LO: if (w_accept) w_next = HDR_HI;
      HDR_HI: begin
        if (w_accept) begin
          if (w_hdr_count == '0)                w_next = DONE;
          else if (32'(w_hdr_count) > 32'(DEPTH)) w_next = ERR;
          else                                  w_next = DATA;
        end else if (w_timeout) begin
          w_next = ERR;
        end
      end
      DATA: begin
        if (w_word_ready && w_last_word) w_next = DONE;
        else if (!w_accept && w_timeout) w_next = ERR;
      end
      DONE, ERR: if (load_req) w_next = HDR_LO;
      default:   w_next = HDR_LO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= HDR_LO;
      r_ctrl      <= '0;
      r_count     <= '0;
      r_word_idx  <= '0;
      r_idle      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state  <= w_next;
      r_ctrl   <= ctrl_for(w_next);
      r_mem_we <= w_word_ready;

      if (w_word_ready) begin
        r_mem_addr  <= r_word_idx;
        r_mem_wdata <= w_word;
        r_word_idx  <= r_word_idx + 1'b1;
      end else if (w_clear) begin
        r_word_idx <= '0;
      end

      if (w_accept && (r_state == HDR_LO)) r_count[7:0]       <= rx_data;
      if (w_accept && (r_state == HDR_HI)) r_count[CNT_W-1:8] <= rx_data;

      // Only the header-high and data phases are bounded in time.
      if (w_accept || !(r_state inside {HDR_HI, DATA})) r_idle <= '0;
      else                                              r_idle <= r_idle + 1'b1;
    end
  end

  assign rx_ready   = r_ctrl.rx_ready;
  assign done       = r_ctrl.done;
  assign error      = r_ctrl.error;
  assign core_reset = r_ctrl.core_reset;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
